// File: rtl/pmem_loader.sv
// Program-memory loader: encodes a brainfuck source byte stream into 3-bit opcodes written from address 0.
// Optional bracket balance check is enabled by defining PMEM_LOADER_BRACKET_CHECK_EN.
module pmem_loader #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 65536,
    parameter int DEPTH_W = 17
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               pmem_we,
    output logic [ADDR_W-1:0]  pmem_addr,
    output logic [2:0]         pmem_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [DEPTH_W-1:0] length
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

    // Returns {is_command, opcode}.
    function automatic logic [3:0] encode(input logic [7:0] b);
        case (b)
            8'h2B:   return 4'b1_000; // +
            8'h2D:   return 4'b1_001; // -
            8'h3E:   return 4'b1_010; // >
            8'h3C:   return 4'b1_011; // <
            8'h5B:   return 4'b1_100; // [
            8'h5D:   return 4'b1_101; // ]
            8'h2E:   return 4'b1_110; // .
            8'h2C:   return 4'b1_111; // ,
            default: return 4'b0_000;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 pmem_we_q, pmem_we_d;
    logic [ADDR_W-1:0]    pmem_addr_q, pmem_addr_d;
    logic [2:0]           pmem_data_q, pmem_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [DEPTH_W-1:0]   length_q, length_d;
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
    logic [DEPTH_W-1:0]   depth_q, depth_d;
`endif

    logic       cmd_vld;
    logic [2:0] cmd_op;
    logic       accept;

    assign {cmd_vld, cmd_op} = encode(in_data);
    assign accept = (state_q == S_LOAD) && in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        pmem_we_d   = 1'b0;
        pmem_addr_d = pmem_addr_q;
        pmem_data_d = pmem_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        length_d    = length_q;
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
        depth_d     = depth_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (cmd_vld) begin
                        if (length_q == DEPTH_W'(DEPTH)) begin
                            state_d    = S_ERROR;
                            in_ready_d = 1'b0;
                            busy_d     = 1'b0;
                            error_d    = 1'b1;
                        end
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
                        else if (cmd_op == 3'd5 && depth_q == '0) begin
                            state_d    = S_ERROR;
                            in_ready_d = 1'b0;
                            busy_d     = 1'b0;
                            error_d    = 1'b1;
                        end
`endif
                        else begin
                            pmem_we_d   = 1'b1;
                            pmem_addr_d = length_q[ADDR_W-1:0];
                            pmem_data_d = cmd_op;
                            length_d    = length_q + DEPTH_W'(1);
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
                            if (cmd_op == 3'd4) depth_d = depth_q + DEPTH_W'(1);
                            if (cmd_op == 3'd5) depth_d = depth_q - DEPTH_W'(1);
`endif
                        end
                    end else if (in_data == 8'h00) begin
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
                        // Unclosed '[' at the terminator aborts instead of completing.
                        if (depth_q != '0) begin
                            state_d = S_ERROR;
                            done_d  = 1'b0;
                            error_d = 1'b1;
                        end
`endif
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d    = S_LOAD;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    length_d   = '0;
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
                    depth_d    = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            pmem_we_q   <= 1'b0;
            pmem_addr_q <= '0;
            pmem_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            length_q    <= '0;
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
            depth_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            pmem_we_q   <= pmem_we_d;
            pmem_addr_q <= pmem_addr_d;
            pmem_data_q <= pmem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            length_q    <= length_d;
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
            depth_q     <= depth_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign pmem_we   = pmem_we_q;
    assign pmem_addr = pmem_addr_q;
    assign pmem_data = pmem_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign length    = length_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Randomized bench for pmem_loader against a string-level reference model.
// A small DEPTH is used so program-memory overflow is reachable.
module tb_pmem_loader;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 8;
    localparam int DEPTH_W = 17;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = 8'h00;
    logic               in_ready;
    logic               pmem_we;
    logic [ADDR_W-1:0]  pmem_addr;
    logic [2:0]         pmem_data;
    logic               busy, done, error;
    logic [DEPTH_W-1:0] length;

    pmem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pmem_we(pmem_we), .pmem_addr(pmem_addr), .pmem_data(pmem_data),
        .busy(busy), .done(done), .error(error), .length(length)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor
    bit mon_en = 1'b0;
    int wr_addr[$], wr_data[$], wr_cyc[$];
    int acc_cyc[$];
    always @(negedge clock) begin
        if (mon_en && pmem_we) begin
            wr_addr.push_back(int'(pmem_addr));
            wr_data.push_back(int'(pmem_data));
            wr_cyc.push_back(cyc);
        end
    end

    // Reference model: walks the source string and decides what a load produces.
    byte unsigned stim[$];
    int exp_addr[$], exp_data[$], exp_src[$];
    int exp_len, exp_consumed;
    bit exp_done, exp_err;

    task automatic model();
        string cmds;
        int depth;
        int op;
        bit bal;
        cmds = "+-><[].,";
        depth = 0;
        exp_addr.delete(); exp_data.delete(); exp_src.delete();
        exp_len = 0; exp_consumed = 0; exp_done = 0; exp_err = 0;
        for (int i = 0; i < stim.size(); i++) begin
            exp_consumed++;
            op = -1;
            for (int k = 0; k < 8; k++) if (cmds[k] == stim[i]) op = k;
            if (stim[i] == 8'h00) begin
                bal = 1'b1;
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
                if (depth != 0) bal = 1'b0;
`endif
                if (bal) exp_done = 1'b1;
                else exp_err = 1'b1;
                break;
            end
            if (op < 0) continue;
            if (exp_len == DEPTH) begin
                exp_err = 1'b1;
                break;
            end
`ifdef PMEM_LOADER_BRACKET_CHECK_EN
            if (op == 5 && depth == 0) begin
                exp_err = 1'b1;
                break;
            end
            if (op == 4) depth++;
            if (op == 5) depth--;
`endif
            exp_addr.push_back(exp_len);
            exp_data.push_back(op);
            exp_src.push_back(i);
            exp_len++;
        end
    endtask

    task automatic set_stim(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
        stim.push_back(8'h00);
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic run_load(input string tag, input bit gaps);
        int waited;
        bit stop;
        int n;
        stop = 1'b0;
        acc_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        pulse_start();
        check_eq({tag, "_busy_on"}, busy, 1);
        mon_en = 1'b1;
        for (int i = 0; i < stim.size() && !stop; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            waited   = 0;
            forever begin
                @(negedge clock);
                if (in_ready) begin
                    acc_cyc.push_back(cyc);
                    @(posedge clock); #1;
                    break;
                end
                waited++;
                if (waited >= 6) begin
                    stop = 1'b1;
                    break;
                end
                @(posedge clock); #1;
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        mon_en = 1'b0;
        model();
        check_eq({tag, "_consumed"}, acc_cyc.size(), exp_consumed);
        check_eq({tag, "_nwrites"}, wr_addr.size(), exp_addr.size());
        n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_addr"}, wr_addr[i], exp_addr[i]);
            check_eq({tag, "_data"}, wr_data[i], exp_data[i]);
            if (exp_src[i] < acc_cyc.size())
                check_eq({tag, "_latency"}, wr_cyc[i] - acc_cyc[exp_src[i]], 1);
        end
        check_eq({tag, "_done"}, done, exp_done);
        check_eq({tag, "_error"}, error, exp_err);
        check_eq({tag, "_length"}, length, exp_len);
        check_eq({tag, "_busy_off"}, busy, 0);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_we_idle"}, pmem_we, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_we"}, pmem_we, 0);
        check_eq({tag, "_addr"}, pmem_addr, 0);
        check_eq({tag, "_data"}, pmem_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_error"}, error, 0);
        check_eq({tag, "_length"}, length, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string alpha;
        string s;
        int nw;
        alpha = "+-><[].,ab \n";

        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;

        set_stim("+-><[].,");
        run_load("all_ops", 1'b0);

        set_stim("a+ b\n-");
        run_load("comments", 1'b0);

        set_stim("+++++++++");
        run_load("overflow", 1'b0);

        // Asynchronous reset in the middle of a load
        pulse_start();
        in_valid = 1'b1;
        in_data  = 8'h2B;
        nw = 0;
        for (int k = 0; k < 20 && nw < 3; k++) begin
            @(negedge clock);
            if (pmem_we) nw++;
        end
        check_eq("midrst_we_before", pmem_we, 1);
        #1 reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        set_stim("+");
        run_load("after_rst", 1'b0);

        for (int r = 0; r < 3; r++) begin
            set_stim("++.");
            run_load("gaps", 1'b1);
        end

        set_stim("]");
        run_load("close_only", 1'b0);
        set_stim("[+");
        run_load("open_only", 1'b0);
        set_stim("[+]");
        run_load("balanced", 1'b0);

        for (int r = 0; r < 6; r++) begin
            s = "";
            for (int k = 0; k < $urandom_range(1, 11); k++) begin
                s = {s, " "};
                s[s.len() - 1] = alpha[$urandom_range(0, alpha.len() - 1)];
            end
            set_stim(s);
            run_load("random", r[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pmem_loader.md
Name: pmem_loader

Overview:
- Writer side of the program-memory interface: fills the 3-bit-opcode program memory that the core reads through pc/pmem_data_read.
- Accepts an ASCII brainfuck source stream over a valid/ready byte handshake and encodes command characters to opcodes. Non-command bytes are dropped.
- Writes opcodes sequentially from address 0. Reports program length, completion and error status.
- Sits beside the core and holds it off (busy) while a load is in progress.

Parameters:
- ADDR_W, 16, program memory address width.
- DEPTH, 65536, maximum number of opcodes stored (must be <= 2**ADDR_W).
- DEPTH_W, 17, width of the length counter (must hold DEPTH).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load (ignored while busy)
- in_valid  in  1  source byte valid
- in_ready  out  1  loader accepts byte this cycle
- in_data  in  8  ASCII source byte
- pmem_we  out  1  program memory write enable
- pmem_addr  out  ADDR_W  program memory write address
- pmem_data  out  3  opcode to write
- busy  out  1  load in progress; core must be held
- done  out  1  load finished successfully (level, until next start)
- error  out  1  load aborted (level, until next start)
- length  out  DEPTH_W  opcodes written in the last load

Behaviour:
- Reset values: state IDLE; in_ready, pmem_we, busy, done, error = 0; pmem_addr, pmem_data, length = 0. Internal bracket depth = 0.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - go to LOAD.
  - clear length, done, error and bracket depth.
  - busy=1 from the next cycle.
- LOAD:
  - in_ready=1.
  - A byte is accepted on a cycle with in_valid && in_ready.
- Opcode encoding: '+'=0, '-'=1, '>'=2, '<'=3, '['=4, ']'=5, '.'=6, ','=7.
- Accepted command byte:
  - Registered write the cycle after acceptance: pmem_we=1 for exactly one cycle, pmem_addr=length (pre-increment), pmem_data=opcode.
  - length increments by 1. Latency from accept to write is 1 cycle.
  - Back-to-back bytes give one write per cycle.
- Accepted non-command byte other than 0x00: discarded. No write, length unchanged.
- Accepted 0x00 (terminator): go to DONE. done=1, busy=0. Terminator is not written.
- Overflow: a command byte accepted while length==DEPTH goes to ERROR (no write).
- DONE/ERROR: in_ready=0, pmem_we=0. length holds its final value.
- start in LOAD is ignored. in_valid outside LOAD is ignored (in_ready=0).
- Asynchronous reset mid-load:
  - immediate return to IDLE with reset values.
  - any pending pmem_we is dropped.
  - partially written memory contents are not cleared.
- pmem_we is never asserted outside LOAD or the single cycle after the final accepted command.

Optional Feature:
- Macro PMEM_LOADER_BRACKET_CHECK_EN enables a bracket balance check.
- When defined:
  - An internal depth counter (DEPTH_W bits) increments on '[' and decrements on ']'.
  - ']' accepted at depth 0 goes to ERROR; that opcode is not written.
  - Terminator with depth != 0 goes to ERROR instead of DONE.
  - length still reports opcodes written before the abort.
- When undefined: no depth counter and no bracket errors. Any bracket sequence loads.

Test Plan:
- Reset, start, stream "+-><[].,",0x00 with in_valid held high:
  - 8 consecutive writes, addresses 0..7, data 0..7.
  - done=1, length=8, busy=0, error=0.
- Stream "a+ b\n-",0x00: exactly 2 writes (addr0=0, addr1=1) and length=2. Comment bytes produce no pmem_we.
- DEPTH=4: stream "+++++":
  - 4 writes, then ERROR on the fifth '+'.
  - error=1, length=4, in_ready=0.
- Assert reset_n low mid-stream after 3 writes: all outputs return to reset values immediately.
  - Then start and "+",0x00 gives length=1 and a write at addr 0.
- Random in_valid gaps on "++.",0x00: writes occur only 1 cycle after each accepted command. Final length=3.
- With PMEM_LOADER_BRACKET_CHECK_EN:
  - "]",0x00 gives error=1, length=0.
  - "[+",0x00 gives error=1, length=2.
  - "[+]",0x00 gives done=1, length=3.
  - Without the macro, "]",0x00 gives done=1, length=1.
